line_window: RTL

- Upstream stage of the `type1` convolution column.
- Takes a raster-order pixel stream, one pixel per cycle when valid, and buffers IMG_NB-1 previous image lines in on-chip memory.
- Emits IMG_NB vertically aligned pixels from consecutive rows, packed exactly as the `img`/`val` inputs of the convolution stage expect.
- Hides row priming: `val` is asserted only when all IMG_NB rows hold real data from the current frame.

---
 rtl/line_window.sv | 132 +++++++++++++
 1 files changed

// File: rtl/line_window.sv
// Line buffer feeding the convolution column: turns a raster pixel stream into IMG_NB vertically aligned pixels.
// Latency: 1 cycle from accepted pixel to img/val; val only once IMG_NB rows of the current frame exist.
// Backpressure: none; every pix_val cycle is accepted, one pixel per cycle sustained.
module line_window #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int LINE_MAX  = 1024,
  parameter int LEN_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LEN_WIDTH-1:0]          line_len,
  input  logic [IMG_WIDTH-1:0]          pix,
  input  logic                          pix_val,
  input  logic                          pix_eof,
  output logic [IMG_WIDTH*IMG_NB-1:0]   img,
  output logic                          val,
  output logic                          busy
);

  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int RW = $clog2(IMG_NB);
  localparam logic [LEN_WIDTH-1:0] LEN_MIN  = LEN_WIDTH'(2);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(LINE_MAX);
  localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_NB - 1);

  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [AW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic                        busy_q, busy_d;
  logic                        val_q, val_d;
  logic [IMG_WIDTH*IMG_NB-1:0] img_q, img_d;

  // mem_q[j] holds the line that is j+1 rows above the incoming one
  logic [IMG_WIDTH-1:0] mem_q [IMG_NB-1][LINE_MAX];
  logic [IMG_WIDTH-1:0] rd_dat [IMG_NB-1];

  logic [LEN_WIDTH-1:0] len_in;
  logic [LEN_WIDTH-1:0] len_cur;
  logic                 col_last;

  // Clamp the requested length; a new frame uses it immediately, an active frame uses the latched copy
  always_comb begin
    len_in = line_len;
    if (line_len < LEN_MIN) begin
      len_in = LEN_MIN;
    end else if (line_len > LEN_MAX) begin
      len_in = LEN_MAX;
    end
    len_cur  = busy_q ? len_q : len_in;
    col_last = (col_q == AW'(len_cur - LEN_WIDTH'(1)));
  end

  // Old line contents at the current column, read before this cycle's write
  always_comb begin
    for (int j = 0; j < IMG_NB - 1; j++) begin
      rd_dat[j] = mem_q[j][col_q];
    end
  end

  // Counter, priming and output-column next state
  always_comb begin
    len_d  = len_q;
    col_d  = col_q;
    row_d  = row_q;
    busy_d = busy_q;
    val_d  = 1'b0;
    img_d  = img_q;
    if (pix_val) begin
      if (!busy_q) begin
        len_d = len_in;
      end
      busy_d = 1'b1;
      if (col_last) begin
        col_d = '0;
        if (row_q != ROW_LAST) begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + AW'(1);
      end
      // Row saturates at ROW_LAST, so equality means every lane holds current-frame data
      if (row_q == ROW_LAST) begin
        val_d = 1'b1;
        img_d[0 +: IMG_WIDTH] = pix;
        for (int k = 1; k < IMG_NB; k++) begin
          img_d[k*IMG_WIDTH +: IMG_WIDTH] = rd_dat[k-1];
        end
      end
      // End of frame restarts priming so the next frame never sees stale rows
      if (pix_eof) begin
        col_d  = '0;
        row_d  = '0;
        busy_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      busy_q <= 1'b0;
      val_q  <= 1'b0;
      img_q  <= '0;
    end else begin
      len_q  <= len_d;
      col_q  <= col_d;
      row_q  <= row_d;
      busy_q <= busy_d;
      val_q  <= val_d;
      img_q  <= img_d;
    end
  end

  // Shift each column down one line: newest pixel into mem 0, each older line moves one memory deeper
  always_ff @(posedge clk) begin
    if (rst && pix_val) begin
      mem_q[0][col_q] <= pix;
      for (int j = 1; j < IMG_NB - 1; j++) begin
        mem_q[j][col_q] <= rd_dat[j-1];
      end
    end
  end

  assign img  = img_q;
  assign val  = val_q;
  assign busy = busy_q;

endmodule
